// File: rtl/packet_rr_arbiter.sv
// packet_rr_arbiter
//   Packet-granular round-robin arbiter for one output port of a stream switch.
//   A source requests this port when it is valid and its destination equals
//   PORT_IDX. One winner is picked per packet (one cycle of arbitration
//   latency). The grant stays locked until that source's last beat transfers,
//   and is then released for exactly one IDLE cycle.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, a stall counter force-releases a lock whose granted source
//     has held valid low for TIMEOUT_CYCLES locked cycles. timeout_o pulses
//     for one cycle on that release. When undefined, timeout_o is tied low.
//
// Ports
//   clk_i          clock, all state on rising edge
//   rst_in         asynchronous active-low reset
//   s_valid_i      per-source valid           [S_DATA_COUNT]
//   s_dest_i       per-source destination     [DW] x S_DATA_COUNT (unpacked)
//   s_last_i       per-source end-of-packet   [S_DATA_COUNT]
//   m_ready_i      ready of output PORT_IDX
//   grant_o        index of the locked source [IW]
//   grant_valid_o  grant_o is locked, safe to steer the datapath
//   timeout_o      one-cycle pulse on forced release

// Per-source request decode: source wants this port.
module packet_rr_req_dec #(
  parameter int DW       = 2,
  parameter int PORT_IDX = 0
) (
  input  logic          valid_i,
  input  logic [DW-1:0] dest_i,
  output logic          req_o
);
  assign req_o = valid_i && (dest_i == DW'(PORT_IDX));
endmodule

module packet_rr_arbiter #(
  parameter  int S_DATA_COUNT   = 2,
  parameter  int M_DATA_COUNT   = 3,
  parameter  int PORT_IDX       = 0,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int DW = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1,
  localparam int IW = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  input  logic [S_DATA_COUNT-1:0] s_valid_i,
  input  logic [DW-1:0]           s_dest_i [S_DATA_COUNT],
  input  logic [S_DATA_COUNT-1:0] s_last_i,
  input  logic                    m_ready_i,
  output logic [IW-1:0]           grant_o,
  output logic                    grant_valid_o,
  output logic                    timeout_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [S_DATA_COUNT-1:0] req;
  logic [IW-1:0]           winner;
  logic                    xfer;

  // ---------------------------------------------------------------------------
  // Request decode, one instance per source
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < S_DATA_COUNT; i++) begin : g_req
    packet_rr_req_dec #(.DW(DW), .PORT_IDX(PORT_IDX)) u_dec (
      .valid_i (s_valid_i[i]),
      .dest_i  (s_dest_i[i]),
      .req_o   (req[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first request strictly after ptr, wrapping. ptr itself
  // is searched last so the previous owner has lowest priority.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic          found;
    int            idx;
    logic [IW-1:0] idx_w;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int off = 1; off <= S_DATA_COUNT; off++) begin
      idx   = (int'(ptr_q) + off) % S_DATA_COUNT;
      idx_w = IW'(idx);
      if (!found && req[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  assign xfer = (state_q == LOCKED) && s_valid_i[grant_q] && m_ready_i;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    stall_cnt_d = '0;
    timeout_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = winner;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
`ifdef ARB_TIMEOUT_EN
        stall_cnt_d = stall_cnt_q;
`endif
        if (xfer) begin
`ifdef ARB_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
          if (s_last_i[grant_q]) begin
            state_d = IDLE;
            ptr_d   = grant_q;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (!s_valid_i[grant_q]) begin
          // This stalled cycle is the TIMEOUT_CYCLES-th: release now.
          if (stall_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = IDLE;
            ptr_d       = grant_q;
            timeout_d   = 1'b1;
            stall_cnt_d = '0;
          end else begin
            stall_cnt_d = stall_cnt_q + CW'(1);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(S_DATA_COUNT - 1);   // source 0 wins first
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign grant_o       = grant_q;
  assign grant_valid_o = (state_q == LOCKED);

endmodule
